// File: rtl/fb_pkg.sv
// Shared types and constants for the SPI framebuffer writer.
// FB_FILL_EN enables the FILL command; without it op 10 is rejected.
package fb_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = 19200;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned ERR_W    = 7;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [1:0]         rsvd0;
    logic [7:0]         x;
    logic               rsvd1;
    logic [6:0]         y;
    logic [COLOR_W-1:0] color;
  } frame_t;

  typedef struct packed {
    op_e                op;
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  // y*160 + x built from shifts: 160 = 128 + 32
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

  function automatic state_e cmd_state(input op_e op);
    return (op == OP_FILL) ? ST_FILL : ST_WRITE;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with registered level and edge-detect outputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      q    <= s2;
      rise <= s2 & ~q;
      fall <= ~s2 & q;
    end
  end

endmodule

// File: rtl/spi_fb_writer.sv
// SPI slave that decodes 32-bit pixel commands into framebuffer writes.
// Define FB_FILL_EN to build the FILL command and its state.
module spi_fb_writer
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               ce,
  output logic               sdo,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_waddr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               busy
);

  logic sck_rise, sck_fall, unused_sck_q;
  logic sdi_q, unused_sdi_rise, unused_sdi_fall;
  logic ce_q, ce_rise, ce_fall;

  sync2 u_sync_sck (.clk(clk), .reset(reset), .d(sck), .q(unused_sck_q), .rise(sck_rise), .fall(sck_fall));
  sync2 u_sync_sdi (.clk(clk), .reset(reset), .d(sdi), .q(sdi_q), .rise(unused_sdi_rise), .fall(unused_sdi_fall));
  sync2 u_sync_ce  (.clk(clk), .reset(reset), .d(ce),  .q(ce_q),  .rise(ce_rise),  .fall(ce_fall));

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_done;
  frame_t             frame;
  logic               unused_rsvd;

  assign frame       = frame_t'(shreg);
  assign unused_rsvd = ^{frame.rsvd0, frame.rsvd1};

  // Shift receiver; saturates at 32 bits until the next ce rise
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (ce_rise) begin
        bit_cnt <= '0;
      end else if (sck_rise && ce_q && (bit_cnt < CNT_W'(FRAME_W))) begin
        shreg      <= {shreg[FRAME_W-2:0], sdi_q};
        bit_cnt    <= bit_cnt + CNT_W'(1);
        frame_done <= (bit_cnt == CNT_W'(FRAME_W - 1));
      end
    end
  end

  state_e             state, state_n;
  cmd_t               pend;
  logic               pend_valid, pend_valid_n, pend_load, take, fill_last;
  logic               drop, short_frame, err_inc;
  logic [ERR_W-1:0]   err_cnt;
  logic               fb_we_n;
  logic [ADDR_W-1:0]  waddr_n;
  logic [COLOR_W-1:0] wdata_n;

`ifdef FB_FILL_EN
  assign fill_last = (state == ST_FILL) && (fb_waddr == ADDR_W'(FB_DEPTH - 1));
`else
  assign fill_last = 1'b0;
`endif

  // The slot is handed over from IDLE, or directly at the end of a fill
  assign take         = pend_valid && ((state == ST_IDLE) || fill_last);
  assign pend_valid_n = pend_load | (pend_valid & ~take);
  assign short_frame  = ce_fall && (bit_cnt != '0) && (bit_cnt < CNT_W'(FRAME_W));
  assign err_inc      = drop | short_frame;

  always_comb begin
    pend_load = 1'b0;
    drop      = 1'b0;
    if (frame_done) begin
      if (pend_valid && !take) begin
        drop = 1'b1;
      end else begin
        case (frame.op)
          OP_NOP: ;
          OP_WRITE: begin
            if ((frame.x < 8'(FB_W)) && (frame.y < 7'(FB_H))) pend_load = 1'b1;
            else                                              drop      = 1'b1;
          end
`ifdef FB_FILL_EN
          OP_FILL: pend_load = 1'b1;
`endif
          default: drop = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend       <= '0;
      err_cnt    <= '0;
    end else begin
      pend_valid <= pend_valid_n;
      if (pend_load) begin
        pend.op    <= frame.op;
        pend.addr  <= pix_addr(frame.x, frame.y);
        pend.color <= frame.color;
      end
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (pend_valid) state_n = cmd_state(pend.op);
      ST_WRITE: state_n = ST_IDLE;
`ifdef FB_FILL_EN
      ST_FILL:  if (fill_last) state_n = pend_valid ? cmd_state(pend.op) : ST_IDLE;
`endif
      default:  state_n = ST_IDLE;
    endcase
  end

  // Next write-port values; address/data hold when no write is issued
  always_comb begin
    fb_we_n = 1'b0;
    waddr_n = fb_waddr;
    wdata_n = fb_wdata;
    if (take) begin
      fb_we_n = 1'b1;
      waddr_n = (pend.op == OP_WRITE) ? pend.addr : '0;
      wdata_n = pend.color;
    end
`ifdef FB_FILL_EN
    else if ((state == ST_FILL) && !fill_last) begin
      fb_we_n = 1'b1;
      waddr_n = fb_waddr + ADDR_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      fb_we    <= fb_we_n;
      fb_waddr <= waddr_n;
      fb_wdata <= wdata_n;
      busy     <= (state_n != ST_IDLE) || pend_valid_n;
    end
  end

  logic [7:0] tx;

  // Status readback: busy first, then err_cnt, zeros once exhausted
  always_ff @(posedge clk) begin
    if (reset) begin
      tx  <= '0;
      sdo <= 1'b0;
    end else if (!ce_q) begin
      sdo <= 1'b0;
    end else if (ce_rise) begin
      tx  <= {err_cnt, 1'b0};
      sdo <= busy;
    end else if (sck_fall) begin
      sdo <= tx[7];
      tx  <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_fb_writer.sv
// Self-checking bench for spi_fb_writer: vector table, random frames vs model, fill/reset sequences.
module tb_spi_fb_writer;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        ce = 1'b0;
  logic        sdo, fb_we, busy;
  logic [14:0] fb_waddr;
  logic [11:0] fb_wdata;

  spi_fb_writer dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce), .sdo(sdo),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; bit busy; } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (fb_we) wq.push_back('{cyc, int'(fb_waddr), int'(fb_wdata), busy});

  int passed = 0;
  int total = 0;
  int exp_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [31:0] mk(input int op, input int x, input int y, input int col);
    logic [31:0] f;
    f = '0;
    f[31:30] = op[1:0];
    f[27:20] = x[7:0];
    f[18:12] = y[6:0];
    f[11:0]  = col[11:0];
    return f;
  endfunction

  function automatic int sat(input int e);
    return (e > 127) ? 127 : e;
  endfunction

  task automatic send_frame(input logic [31:0] f, input int nbits, output logic [7:0] st);
    st = '0;
    @(negedge clk); ce = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = f[31-i];
      repeat (HALF) @(negedge clk);
      if (i < 8) st[7-i] = sdo;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ce = 1'b0; sdi = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic readback_chk(input string name);
    logic [7:0] st;
    send_frame(32'h0, 32, st);
    chk(name, int'(st), exp_err);
  endtask

  task automatic run_frame(input string name, input int op, input int x, input int y, input int col,
                           input int nbits, input bit exp_we, input int exp_addr, input int exp_data);
    logic [7:0] st;
    int n0, n;
    n0 = wq.size();
    send_frame(mk(op, x, y, col), nbits, st);
    repeat (4) @(negedge clk);
    n = wq.size() - n0;
    chk({name, "_wcount"}, n, exp_we ? 1 : 0);
    if (exp_we && n >= 1) begin
      chk({name, "_addr"}, wq[n0].addr, exp_addr);
      chk({name, "_data"}, wq[n0].data, exp_data);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_we"}, int'(fb_we), 0);
    chk({name, "_waddr"}, int'(fb_waddr), 0);
    chk({name, "_wdata"}, int'(fb_wdata), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_sdo"}, int'(sdo), 0);
  endtask

  typedef struct {
    int op; int x; int y; int col; int nbits;
    bit exp_we; int exp_addr; int exp_data; int err_inc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] st;
    int op, x, y, col, nbits, ea, n0, nw, bad, c0;
    bit ew, done, found;

    tbl[0]  = '{1, 10, 5, 'hABC, 32, 1'b1, 810, 'hABC, 0};
    tbl[1]  = '{1, 160, 0, 'h123, 32, 1'b0, 0, 0, 1};
    tbl[2]  = '{1, 159, 119, 'h5A5, 32, 1'b1, 19199, 'h5A5, 0};
    tbl[3]  = '{1, 0, 120, 'h111, 32, 1'b0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0, 'hFFF, 32, 1'b1, 0, 'hFFF, 0};
    tbl[5]  = '{3, 20, 20, 'h222, 32, 1'b0, 0, 0, 1};
    tbl[6]  = '{0, 5, 5, 'h333, 32, 1'b0, 0, 0, 0};
    tbl[7]  = '{1, 10, 5, 'hABC, 12, 1'b0, 0, 0, 1};
    tbl[8]  = '{1, 10, 5, 'hABC, 1, 1'b0, 0, 0, 1};
    tbl[9]  = '{1, 10, 5, 'hABC, 0, 1'b0, 0, 0, 0};
    tbl[10] = '{1, 255, 127, 'h444, 32, 1'b0, 0, 0, 1};
    tbl[11] = '{1, 1, 1, 'h07E, 32, 1'b1, 161, 'h07E, 0};

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].nbits,
                tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_data);
      exp_err = sat(exp_err + tbl[i].err_inc);
      readback_chk($sformatf("vec%0d_status", i));
    end

    for (int k = 0; k < 16; k++) begin
      op = $urandom_range(0, 3);
`ifdef FB_FILL_EN
      if (op == 2) op = 1;
`endif
      x = $urandom_range(0, 200);
      y = $urandom_range(0, 127);
      col = $urandom_range(0, 4095);
      nbits = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : 32;
      ew = 1'b0; ea = 0;
      if (nbits > 0 && nbits < 32) exp_err = sat(exp_err + 1);
      else if (nbits == 32) begin
        if (op == 1 && x < 160 && y < 120) begin ew = 1'b1; ea = y * 160 + x; end
        else if (op != 0) exp_err = sat(exp_err + 1);
      end
      run_frame($sformatf("rand%0d", k), op, x, y, col, nbits, ew, ea, col);
    end
    readback_chk("rand_status");

`ifdef FB_FILL_EN
    n0 = wq.size();
    send_frame(mk(2, 7, 7, 'hF00), 32, st);
    send_frame(mk(1, 0, 0, 'h0F0), 32, st);
    send_frame(mk(1, 1, 1, 'h555), 32, st);
    exp_err = sat(exp_err + 1);
    done = 1'b0;
    for (int t = 0; t < 25000 && !done; t++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("fill_done", int'(done), 1);
    repeat (4) @(negedge clk);
    nw = wq.size() - n0;
    chk("fill_wcount", nw, 19201);
    bad = 0;
    c0 = (nw > 0) ? wq[n0].cyc : 0;
    for (int i = 0; i < 19200 && i < nw; i++)
      if (wq[n0+i].addr != i || wq[n0+i].data != 'hF00 || wq[n0+i].cyc != c0 + i || !wq[n0+i].busy) bad++;
    chk("fill_contig", bad, 0);
    if (nw >= 19201) begin
      chk("post_fill_addr", wq[n0+19200].addr, 0);
      chk("post_fill_data", wq[n0+19200].data, 'h0F0);
      chk("post_fill_cycle", wq[n0+19200].cyc - c0, 19200);
    end
    chk("fill_busy_low", int'(busy), 0);
    readback_chk("fill_status");
    wq.delete();
`else
    run_frame("fill_disabled", 2, 0, 0, 'hF00, 32, 1'b0, 0, 0);
    exp_err = sat(exp_err + 1);
    readback_chk("fill_disabled_status");
`endif

    n0 = wq.size();
    for (int i = 0; i < 130; i++) send_frame(mk(1, 10, 5, 'hABC), 12, st);
    chk("sat_nowrite", wq.size() - n0, 0);
    exp_err = sat(exp_err + 130);
    readback_chk("sat_status");

`ifdef FB_FILL_EN
    send_frame(mk(2, 0, 0, 'h00F), 32, st);
    found = 1'b0;
    for (int t = 0; t < 6000 && !found; t++) begin
      if (fb_we && fb_waddr == 15'd5000) found = 1'b1;
      else @(negedge clk);
    end
    chk("fill_reach_5000", int'(found), 1);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_err = 0;
    readback_chk("midreset_status");
    run_frame("post_reset_write", 1, 3, 2, 'hC3C, 32, 1'b1, 323, 'hC3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
